// File: rtl/board_i2c_target.sv
// I2C target for board checkout scans: ACKs one 7-bit address and exposes a small
// register file reached through a pointer byte.

module board_i2c_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_b,
    input  logic pin,
    output logic level
);

    logic [1:0] sync_r;
    logic       level_r;
    logic [3:0] cnt_r;

    // Two-flop synchronizer followed by a run-length filter on the synchronized level
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            sync_r  <= 2'b11;
            level_r <= 1'b1;
            cnt_r   <= 4'd0;
        end else begin
            sync_r <= {sync_r[0], pin};
            if (sync_r[1] != level_r) begin
                if (cnt_r == 4'(FILTER_LEN - 1)) begin
                    level_r <= sync_r[1];
                    cnt_r   <= 4'd0;
                end else begin
                    cnt_r <= cnt_r + 4'd1;
                end
            end else begin
                cnt_r <= 4'd0;
            end
        end
    end

    assign level = level_r;

endmodule

module board_i2c_target #(
    parameter logic [6:0] ADDR       = 7'h50,
    parameter int         NUM_REGS   = 16,
    parameter int         FILTER_LEN = 3
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        scl_i,
    input  logic                        sda_i,
    output logic                        sda_o,
    output logic                        sda_t,
    output logic [NUM_REGS*8-1:0]       regs_o,
    output logic                        wr_stb,
    output logic [$clog2(NUM_REGS)-1:0] wr_idx,
    output logic                        busy
);

    localparam int PW = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK
    } state_t;

    state_t              state_r, state_nxt;
    logic [3:0]          bit_cnt_r, bit_cnt_nxt;
    logic [7:0]          shift_r, shift_nxt;
    logic [PW-1:0]       ptr_r, ptr_nxt;
    logic                first_r, first_nxt;
    logic                rw_r, rw_nxt;
    logic                sda_t_r, sda_t_nxt;
    logic                busy_r, busy_nxt;
    logic                wr_stb_r, wr_stb_nxt;
    logic [PW-1:0]       wr_idx_r;
    logic [NUM_REGS*8-1:0] regs_r;
    logic                reg_we_s;

    logic scl_f_s, sda_f_s, scl_prev_r, sda_prev_r;
    logic scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [7:0]    rx_byte_s, cur_reg_s;
    logic [PW-1:0] ptr_inc_s;

    board_i2c_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(clk), .rst_b(rst_b), .pin(scl_i), .level(scl_f_s)
    );
    board_i2c_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(clk), .rst_b(rst_b), .pin(sda_i), .level(sda_f_s)
    );

    assign scl_rise_s = scl_f_s & ~scl_prev_r;
    assign scl_fall_s = ~scl_f_s & scl_prev_r;
    assign start_s    = scl_f_s & ~sda_f_s & sda_prev_r;
    assign stop_s     = scl_f_s & sda_f_s & ~sda_prev_r;
    assign rx_byte_s  = {shift_r[6:0], sda_f_s};
    assign cur_reg_s  = regs_r[{ptr_r, 3'b000} +: 8];
    assign ptr_inc_s  = ptr_r + {{(PW-1){1'b0}}, 1'b1};

    // Next-state and output decode; START/STOP override every state
    always_comb begin
        state_nxt   = state_r;
        bit_cnt_nxt = bit_cnt_r;
        shift_nxt   = shift_r;
        ptr_nxt     = ptr_r;
        first_nxt   = first_r;
        rw_nxt      = rw_r;
        sda_t_nxt   = sda_t_r;
        busy_nxt    = busy_r;
        wr_stb_nxt  = 1'b0;
        reg_we_s    = 1'b0;
        if (start_s) begin
            state_nxt   = ST_ADDR;
            bit_cnt_nxt = 4'd0;
            busy_nxt    = 1'b1;
            sda_t_nxt   = 1'b1;
        end else if (stop_s) begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
            sda_t_nxt = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sda_t_nxt = 1'b1;
                end
                ST_ADDR: begin
                    if (scl_rise_s && bit_cnt_r < 4'd8) begin
                        shift_nxt   = rx_byte_s;
                        bit_cnt_nxt = bit_cnt_r + 4'd1;
                        rw_nxt      = rx_byte_s[0];
                        // Address 0 is the general call and never gets an ACK
                        if (bit_cnt_r == 4'd7 &&
                            (rx_byte_s[7:1] != ADDR || rx_byte_s[7:1] == 7'd0)) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_ADDR;
                        end
                    end else if (scl_fall_s && bit_cnt_r == 4'd8) begin
                        sda_t_nxt = 1'b0;
                        state_nxt = ST_ADDR_ACK;
                    end else begin
                        state_nxt = ST_ADDR;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall_s) begin
                        if (rw_r) begin
                            shift_nxt   = cur_reg_s;
                            sda_t_nxt   = cur_reg_s[7];
                            bit_cnt_nxt = 4'd1;
                            state_nxt   = ST_RD_BYTE;
                        end else begin
                            sda_t_nxt   = 1'b1;
                            bit_cnt_nxt = 4'd0;
                            first_nxt   = 1'b1;
                            state_nxt   = ST_WR_BYTE;
                        end
                    end else begin
                        state_nxt = ST_ADDR_ACK;
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise_s && bit_cnt_r < 4'd8) begin
                        shift_nxt   = rx_byte_s;
                        bit_cnt_nxt = bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd7) begin
                            if (first_r) begin
                                ptr_nxt   = rx_byte_s[PW-1:0];
                                first_nxt = 1'b0;
                            end else begin
                                reg_we_s   = 1'b1;
                                wr_stb_nxt = 1'b1;
                                ptr_nxt    = ptr_inc_s;
                            end
                        end else begin
                            first_nxt = first_r;
                        end
                    end else if (scl_fall_s && bit_cnt_r == 4'd8) begin
                        sda_t_nxt = 1'b0;
                        state_nxt = ST_WR_ACK;
                    end else begin
                        state_nxt = ST_WR_BYTE;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall_s) begin
                        sda_t_nxt   = 1'b1;
                        bit_cnt_nxt = 4'd0;
                        state_nxt   = ST_WR_BYTE;
                    end else begin
                        state_nxt = ST_WR_ACK;
                    end
                end
                ST_RD_BYTE: begin
                    // bit_cnt counts bits already presented; 8 means the last bit just ended
                    if (scl_fall_s) begin
                        if (bit_cnt_r == 4'd8) begin
                            sda_t_nxt   = 1'b1;
                            ptr_nxt     = ptr_inc_s;
                            bit_cnt_nxt = 4'd0;
                            state_nxt   = ST_RD_ACK;
                        end else begin
                            sda_t_nxt   = shift_r[6];
                            shift_nxt   = {shift_r[6:0], 1'b0};
                            bit_cnt_nxt = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        state_nxt = ST_RD_BYTE;
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise_s) begin
                        if (sda_f_s) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            bit_cnt_nxt = 4'd1;
                        end
                    end else if (scl_fall_s && bit_cnt_r == 4'd1) begin
                        shift_nxt   = cur_reg_s;
                        sda_t_nxt   = cur_reg_s[7];
                        bit_cnt_nxt = 4'd1;
                        state_nxt   = ST_RD_BYTE;
                    end else begin
                        state_nxt = ST_RD_ACK;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    sda_t_nxt = 1'b1;
                end
            endcase
        end
    end

    // State, datapath and register file update
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'd0;
            ptr_r      <= {PW{1'b0}};
            first_r    <= 1'b0;
            rw_r       <= 1'b0;
            sda_t_r    <= 1'b1;
            busy_r     <= 1'b0;
            wr_stb_r   <= 1'b0;
            wr_idx_r   <= {PW{1'b0}};
            regs_r     <= {(NUM_REGS*8){1'b0}};
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            state_r    <= state_nxt;
            bit_cnt_r  <= bit_cnt_nxt;
            shift_r    <= shift_nxt;
            ptr_r      <= ptr_nxt;
            first_r    <= first_nxt;
            rw_r       <= rw_nxt;
            sda_t_r    <= sda_t_nxt;
            busy_r     <= busy_nxt;
            wr_stb_r   <= wr_stb_nxt;
            scl_prev_r <= scl_f_s;
            sda_prev_r <= sda_f_s;
            if (reg_we_s) begin
                regs_r[{ptr_r, 3'b000} +: 8] <= rx_byte_s;
                wr_idx_r <= ptr_r;
            end else begin
                wr_idx_r <= wr_idx_r;
            end
        end
    end

    assign sda_o  = 1'b0;
    assign sda_t  = sda_t_r;
    assign regs_o = regs_r;
    assign wr_stb = wr_stb_r;
    assign wr_idx = wr_idx_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_board_i2c_target.sv
// Directed bench for board_i2c_target: a bit-banged I2C master drives an open-drain bus
// and the results are compared against hand-computed values and a small register model.

module tb_board_i2c_target;

    localparam int NR = 16;
    localparam int Q  = 12;

    logic              clk = 1'b0;
    logic              rst_b = 1'b0;
    logic              scl_m = 1'b1;
    logic              sda_m = 1'b1;
    logic              sda_o, sda_t, wr_stb, busy;
    logic [NR*8-1:0]   regs_o;
    logic [3:0]        wr_idx;
    wire               sda_bus = sda_m & (sda_t | sda_o);

    int                checks = 0;
    int                errors = 0;
    int                drive_cnt = 0;
    logic [3:0]        stb_q[$];
    logic [7:0]        exp_regs [NR];
    logic              ack;
    logic [7:0]        rd;

    always #5 clk = ~clk;

    board_i2c_target #(.ADDR(7'h50), .NUM_REGS(NR), .FILTER_LEN(3)) dut (
        .clk(clk), .rst_b(rst_b), .scl_i(scl_m), .sda_i(sda_bus),
        .sda_o(sda_o), .sda_t(sda_t), .regs_o(regs_o),
        .wr_stb(wr_stb), .wr_idx(wr_idx), .busy(busy)
    );

    // Record every SDA drive cycle and every write strobe
    always @(negedge clk) begin
        if (sda_t === 1'b0) drive_cnt++;
        if (wr_stb === 1'b1) stb_q.push_back(wr_idx);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] flat();
        logic [127:0] f;
        for (int k = 0; k < NR; k++) f[8*k +: 8] = exp_regs[k];
        return f;
    endfunction

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;  wclk(Q);
        scl_m = 1'b1; wclk(2*Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        b = sda_bus;  wclk(Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        read_bit(a);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic a);
        logic b;
        d = 8'd0;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        send_bit(a);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        sda_m = 1'b0; wclk(Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        sda_m = 1'b1; wclk(Q);
    endtask

    task automatic send_ack(input string tag, input logic [7:0] d);
        logic a;
        send_byte(d, a);
        check(tag, {127'd0, a}, 128'd0);
    endtask

    task automatic read_txn(input logic [7:0] p, input logic [7:0] e0, input logic [7:0] e1);
        stb_q.delete();
        i2c_start();
        send_ack("rd_addr_w", 8'hA0);
        send_ack("rd_ptr", p);
        i2c_start();
        send_ack("rd_addr_r", 8'hA1);
        recv_byte(rd, 1'b0);
        check("rd_data0", {120'd0, rd}, {120'd0, e0});
        recv_byte(rd, 1'b1);
        check("rd_data1", {120'd0, rd}, {120'd0, e1});
        drive_cnt = 0;
        wclk(20);
        check("rd_release_after_nack", {127'd0, sda_t}, 128'd1);
        check("rd_no_drive_after_nack", 128'(drive_cnt), 128'd0);
        check("rd_busy_until_stop", {127'd0, busy}, 128'd1);
        i2c_stop();
        check("rd_busy_after_stop", {127'd0, busy}, 128'd0);
        check("rd_no_wr_stb", 128'(stb_q.size()), 128'd0);
    endtask

    initial begin
        for (int k = 0; k < NR; k++) exp_regs[k] = 8'h00;

        // Reset state
        wclk(5);
        check("rst_sda_t", {127'd0, sda_t}, 128'd1);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_wr_stb", {127'd0, wr_stb}, 128'd0);
        rst_b = 1'b1;
        wclk(5);
        check("rst_regs", regs_o, 128'd0);

        // SCL activity without START
        drive_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            scl_m = ~scl_m;
            wclk(Q);
        end
        check("nostart_drive", 128'(drive_cnt), 128'd0);
        check("nostart_busy", {127'd0, busy}, 128'd0);

        // Scan: matching then non-matching address
        i2c_start();
        check("scan_busy", {127'd0, busy}, 128'd1);
        send_ack("scan_ack", 8'hA0);
        i2c_stop();
        check("scan_busy_stop", {127'd0, busy}, 128'd0);
        drive_cnt = 0;
        i2c_start();
        send_byte(8'hA2, ack);
        check("scan_nack", {127'd0, ack}, 128'd1);
        i2c_stop();
        check("scan_nack_drive", 128'(drive_cnt), 128'd0);
        check("scan_nack_busy", {127'd0, busy}, 128'd0);

        // General call is not acknowledged
        i2c_start();
        send_byte(8'h00, ack);
        check("gencall_nack", {127'd0, ack}, 128'd1);
        i2c_stop();

        // Write ptr 3, data 0x11 0x22
        stb_q.delete();
        i2c_start();
        send_ack("wr_addr", 8'hA0);
        send_ack("wr_ptr", 8'h03);
        send_ack("wr_d0", 8'h11);
        send_ack("wr_d1", 8'h22);
        i2c_stop();
        exp_regs[3] = 8'h11;
        exp_regs[4] = 8'h22;
        check("wr_stb_count", 128'(stb_q.size()), 128'd2);
        if (stb_q.size() == 2) begin
            check("wr_idx0", {124'd0, stb_q[0]}, 128'd3);
            check("wr_idx1", {124'd0, stb_q[1]}, 128'd4);
        end else begin
            check("wr_idx_missing", 128'(stb_q.size()), 128'd2);
        end
        check("wr_regs", regs_o, flat());

        // Read back with repeated START
        read_txn(8'h03, 8'h11, 8'h22);

        // Write wrap 15 -> 0
        stb_q.delete();
        i2c_start();
        send_ack("wrap_addr", 8'hA0);
        send_ack("wrap_ptr", 8'h0F);
        send_ack("wrap_d0", 8'hAA);
        send_ack("wrap_d1", 8'hBB);
        i2c_stop();
        exp_regs[15] = 8'hAA;
        exp_regs[0]  = 8'hBB;
        check("wrap_regs", regs_o, flat());
        check("wrap_stb_count", 128'(stb_q.size()), 128'd2);
        if (stb_q.size() == 2) check("wrap_idx1", {124'd0, stb_q[1]}, 128'd0);
        else check("wrap_idx_missing", 128'(stb_q.size()), 128'd2);

        // Read wrap 15 -> 0
        read_txn(8'h0F, 8'hAA, 8'hBB);

        // Pointer byte 0x13 masks to 3
        stb_q.delete();
        i2c_start();
        send_ack("mask_addr", 8'hA0);
        send_ack("mask_ptr", 8'h13);
        send_ack("mask_d0", 8'h55);
        i2c_stop();
        exp_regs[3] = 8'h55;
        check("mask_regs", regs_o, flat());
        if (stb_q.size() == 1) check("mask_idx", {124'd0, stb_q[0]}, 128'd3);
        else check("mask_stb_count", 128'(stb_q.size()), 128'd1);

        // One-cycle SCL glitch before the address byte
        i2c_start();
        sda_m = 1'b1;
        wclk(Q/2);
        scl_m = 1'b1; wclk(1);
        scl_m = 1'b0; wclk(Q);
        send_ack("glitch_addr", 8'hA0);
        send_ack("glitch_ptr", 8'h01);
        send_ack("glitch_d0", 8'h5A);
        i2c_stop();
        exp_regs[1] = 8'h5A;
        check("glitch_regs", regs_o, flat());

        // STOP in the middle of a data byte
        stb_q.delete();
        i2c_start();
        send_ack("midstop_addr", 8'hA0);
        send_ack("midstop_ptr", 8'h02);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_stop();
        check("midstop_regs", regs_o, flat());
        check("midstop_no_stb", 128'(stb_q.size()), 128'd0);
        check("midstop_busy", {127'd0, busy}, 128'd0);

        // Reset while presenting a 0 read bit (reg 3 = 0x55, MSB 0)
        i2c_start();
        send_ack("rstrd_addr_w", 8'hA0);
        send_ack("rstrd_ptr", 8'h03);
        i2c_start();
        send_ack("rstrd_addr_r", 8'hA1);
        check("rstrd_driving0", {127'd0, sda_t}, 128'd0);
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        check("rstrd_release", {127'd0, sda_t}, 128'd1);
        check("rstrd_busy", {127'd0, busy}, 128'd0);
        check("rstrd_state", {125'd0, dut.state_r}, 128'd0);
        wclk(2);
        rst_b = 1'b1;
        for (int k = 0; k < NR; k++) exp_regs[k] = 8'h00;
        i2c_stop();
        check("rstrd_regs", regs_o, flat());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_i2c_target.md
Name: board_i2c_target

Overview:
- I2C target (responder) that answers the bus scanner used on board checkout builds. Gives the scanner a known device to find and a small register file to write and read back.
- Used in two places:
  - in the checkout simulation bench, as the device on the far end of each scanned bus;
  - on a second FPGA or loopback build, where it sits behind an IOBUF on SDA.
- Plain oversampled design: SCL and SDA are sampled in the clk domain, and the target never drives SCL (no clock stretching).

Parameters:
- ADDR, 7'h50, 7-bit target address that gets an ACK.
- NUM_REGS, 16, number of 8-bit registers. Must be a power of 2, from 2 to 256.
- FILTER_LEN, 3, number of consecutive identical synchronized samples needed before a filtered SCL/SDA level changes (1..15).

Ports:
- clk  input  1  system clock; at least 20x SCL.
- rst_b  input  1  synchronous, active-low reset.
- scl_i  input  1  SCL input from IOBUF O.
- sda_i  input  1  SDA input from IOBUF O.
- sda_o  output  1  SDA drive value; always 0.
- sda_t  output  1  SDA tristate: 1 = released, 0 = drive low.
- regs_o  output  NUM_REGS*8  register file, flattened; reg k is at [8k +: 8].
- wr_stb  output  1  one-cycle pulse when a register is written over I2C.
- wr_idx  output  $clog2(NUM_REGS)  index written; valid while wr_stb=1.
- busy  output  1  high from START to STOP.

Behaviour:
- Reset (rst_b=0 at a clk edge) sets:
  - sda_t=1, all regs=0, ptr=0, wr_stb=0, wr_idx=0, busy=0;
  - state=IDLE, synchronizers and filters to 1.
- Reset mid-transfer releases SDA on the next edge. Reset has priority over all bus events.
- Input conditioning:
  - Each of scl_i and sda_i goes through a 2-FF synchronizer, then a filter.
  - The filtered level changes only after FILTER_LEN consecutive equal samples that differ from the current level.
  - Edges are detected on the filtered signals as one-cycle flags.
- Bus events, decided on filtered levels:
  - START = SDA falls while SCL=1.
  - STOP = SDA rises while SCL=1.
  - Bit sample = SCL rising edge.
  - Drive point = SCL falling edge; sda_t updates on the cycle after the detected falling edge.
- Precedence: START or STOP in any state overrides everything else.
  - START (including repeated START): state→ADDR, bit count cleared, busy=1, sda_t=1.
  - STOP: state→IDLE, busy=0, sda_t=1.
  - ptr is kept across transactions.
- States:
  - IDLE: ignore SCL edges.
  - ADDR: shift in 8 bits, MSB first. After the 8th rising edge, compare bits[7:1] against ADDR.
    - Match → at the next falling edge drive ACK (sda_t=0) and enter ADDR_ACK. Store R/W = bit0.
    - Mismatch → IDLE with SDA never driven, so the master sees a NACK.
  - ADDR_ACK: at the falling edge that ends the ACK bit, sda_t=1.
    - W → WR_BYTE, with first_byte=1.
    - R → load shift register with regs[ptr], drive its MSB (sda_t = bit), enter RD_BYTE.
  - WR_BYTE: shift 8 bits. On the 8th rising edge:
    - if first_byte: ptr = byte mod NUM_REGS, then first_byte=0;
    - else: regs[ptr]=byte, wr_stb=1 and wr_idx=ptr for that one cycle, then ptr = (ptr+1) mod NUM_REGS.
    - Either way, at the next falling edge drive ACK and enter WR_ACK.
  - WR_ACK: at the ending falling edge, release SDA → WR_BYTE.
  - RD_BYTE:
    - Present bit n at each falling edge: sda_t=0 for a 0 bit, 1 for a 1 bit.
    - After the 8th bit's falling edge, release SDA, set ptr=ptr+1 with wrap, and enter RD_ACK.
  - RD_ACK: sample SDA at the rising edge.
    - 0 (master ACK) → at the falling edge load regs[ptr] and drive its MSB → RD_BYTE.
    - 1 (NACK) → IDLE with SDA released; busy stays 1 until STOP.
- Wrap-around: the pointer wraps from NUM_REGS-1 to 0 on both write and read.
- A pointer byte ≥ NUM_REGS is masked to its low bits.
- General call (address 0) gets no ACK.

Test Plan:
- Reset → sda_t=1, busy=0, regs_o=0; SCL toggling with no START produces no SDA activity.
- Scan: START, addr byte 0xA0 (7'h50 W), STOP → ACK on 9th clock. Then START, 0xA2 (7'h51) → SDA stays released (NACK) and busy=0 after STOP.
- Write: START, 0xA0, 0x03, 0x11, 0x22, STOP →
  - ACK on all four bytes;
  - wr_stb pulses with wr_idx=3 then 4;
  - regs[3]=0x11, regs[4]=0x22.
- Read with repeated START: START, 0xA0, 0x03, Sr, 0xA1, read 2 bytes (master ACK then NACK), STOP →
  - data 0x11 then 0x22;
  - SDA released after the NACK;
  - no wr_stb.
- Wrap: write ptr 0x0F, then data 0xAA, 0xBB → regs[15]=0xAA, regs[0]=0xBB. Pointer byte 0x13 → ptr=3.
- Robustness:
  - a 1-cycle glitch on SCL during ADDR is ignored;
  - rst_b=0 while driving a read 0 bit → sda_t=1 on the next edge and state=IDLE;
  - STOP in the middle of WR_BYTE → no register changes.
